icache_refill: RTL and testbench

Line-refill engine between the instruction cache and the AXI read arbiter. It accepts one miss at a time and issues a single line-aligned read burst on the arbiter's I-side channel. It assembles the returned beats into a full cache line and forwards the critical (missed) word as soon as it arrives. It hands the completed line back to the cache with a one-cycle valid pulse.

---
 rtl/icache_refill.sv | 180 ++++++++++++++++++
 tb/tb_icache_refill.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill
// Description : Instruction-cache line-refill engine. Accepts one miss at a
//               time, issues one line-aligned read burst of WORDS beats on the
//               I-side channel of the AXI read arbiter, and collects the
//               returned beats into a line buffer. The missed (critical) word
//               is forwarded combinationally as it arrives. The finished line
//               is handed back to the cache with a one-cycle valid pulse.
//
// Ports       : clk, rst                 clock, async active-high reset
//               miss_req/miss_addr       refill request from the cache
//               miss_ready               engine idle, miss can be taken
//               crit_valid/crit_data     critical word, same cycle as beat
//               refill_valid/addr/line   completed line (one-cycle pulse)
//               refill_err               line came from a malformed burst
//               i_ar*                    AR channel to the arbiter
//               i_r*                     R channel from the arbiter
// Revision    : 1.0  initial release
// ============================================================================
module icache_refill #(
    parameter int WORDS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_req,
    input  logic [31:0]          miss_addr,
    output logic                 miss_ready,
    output logic                 crit_valid,
    output logic [31:0]          crit_data,
    output logic                 refill_valid,
    output logic [31:0]          refill_addr,
    output logic [32*WORDS-1:0]  refill_line,
    output logic                 refill_err,
    output logic [31:0]          i_araddr,
    output logic [3:0]           i_arlen,
    output logic                 i_arvalid,
    input  logic                 i_arready,
    input  logic [31:0]          i_rdata,
    input  logic                 i_rlast,
    input  logic                 i_rvalid,
    output logic                 i_rready
);

    localparam int OFF_W = $clog2(WORDS) + 2;
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_line_addr;
    logic [IDX_W-1:0]   r_crit_off;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic [31:0]        r_buf [WORDS];

    logic               w_accept;
    logic               w_beat;
    logic               w_unused_addr_lsb;

    // Word-within-line index ignores the byte lane bits.
    assign w_unused_addr_lsb = ^miss_addr[1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        miss_ready   = 1'b0;
        i_arvalid    = 1'b0;
        i_rready     = 1'b0;
        refill_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                miss_ready = 1'b1;
                if (miss_req) begin
                    w_state_nxt = S_AR;
                end
            end
            S_AR: begin
                i_arvalid = 1'b1;
                if (i_arready) begin
                    w_state_nxt = S_R;
                end
            end
            S_R: begin
                i_rready = 1'b1;
                if (i_rvalid && i_rlast) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                refill_valid = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && miss_req;
    // i_rready is 1 throughout R, so every valid beat there is accepted.
    assign w_beat   = (r_state == S_R) && i_rvalid;

    // ------------------------------------------------------------------
    // Datapath: request latch, beat counter, line buffer, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_addr <= '0;
            r_crit_off  <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                r_buf[k] <= '0;
            end
        end else if (w_accept) begin
            r_line_addr <= {miss_addr[31:OFF_W], {OFF_W{1'b0}}};
            r_crit_off  <= miss_addr[OFF_W-1:2];
            r_cnt       <= '0;
            r_err       <= 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                r_buf[k] <= '0;
            end
        end else if (w_beat) begin
            // Counter saturates at WORDS; surplus beats are dropped.
            if (r_cnt != C_CNT_FULL) begin
                r_buf[r_cnt[IDX_W-1:0]] <= i_rdata;
                r_cnt                   <= r_cnt + 1'b1;
            end
            // Malformed burst: a beat beyond the line, or rlast on any beat
            // other than the last word of the line.
            if ((r_cnt == C_CNT_FULL) || (i_rlast && (r_cnt != C_CNT_LAST))) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The counter only moves forward on accepted beats, so the match with
    // the critical offset can occur at most once per miss.
    assign crit_valid  = w_beat && (r_cnt == {1'b0, r_crit_off});
    assign crit_data   = i_rdata;

    assign i_araddr    = r_line_addr;
    assign i_arlen     = 4'(WORDS - 1);

    assign refill_addr = r_line_addr;
    assign refill_err  = r_err && (r_state == S_DONE);

    for (genvar k = 0; k < WORDS; k++) begin : g_pack
        assign refill_line[32*k +: 32] = r_buf[k];
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill
// Description : Self-checking bench for icache_refill. A miss-level model
//               derives the expected line, critical word, error flag and
//               cycle-by-cycle channel activity from the burst description
//               (address, AR stall count, beat count, gap pattern).
// Revision    : 1.0  initial release
// ============================================================================
module tb_icache_refill;

    localparam int WORDS = 8;
    localparam int LW    = 32 * WORDS;
    localparam int OFF_W = $clog2(WORDS) + 2;

    logic              clk;
    logic              rst;
    logic              miss_req;
    logic [31:0]       miss_addr;
    logic              miss_ready;
    logic              crit_valid;
    logic [31:0]       crit_data;
    logic              refill_valid;
    logic [31:0]       refill_addr;
    logic [LW-1:0]     refill_line;
    logic              refill_err;
    logic [31:0]       i_araddr;
    logic [3:0]        i_arlen;
    logic              i_arvalid;
    logic              i_arready;
    logic [31:0]       i_rdata;
    logic              i_rlast;
    logic              i_rvalid;
    logic              i_rready;

    int checks = 0;
    int errors = 0;

    icache_refill #(.WORDS(WORDS)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .miss_ready   (miss_ready),
        .crit_valid   (crit_valid),
        .crit_data    (crit_data),
        .refill_valid (refill_valid),
        .refill_addr  (refill_addr),
        .refill_line  (refill_line),
        .refill_err   (refill_err),
        .i_araddr     (i_araddr),
        .i_arlen      (i_arlen),
        .i_arvalid    (i_arvalid),
        .i_arready    (i_arready),
        .i_rdata      (i_rdata),
        .i_rlast      (i_rlast),
        .i_rvalid     (i_rvalid),
        .i_rready     (i_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Idle cycles with stray R traffic that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            miss_req  = 1'b0;
            i_rvalid  = 1'($urandom);
            i_rdata   = $urandom;
            i_rlast   = 1'($urandom);
            i_arready = 1'($urandom);
            #1;
            check_eq("idle_miss_ready", miss_ready, 1);
            check_eq("idle_arvalid", i_arvalid, 0);
            check_eq("idle_rready", i_rready, 0);
            check_eq("idle_refill_valid", refill_valid, 0);
            check_eq("idle_crit_valid", crit_valid, 0);
        end
    endtask

    // One complete miss. nbeats is the burst length actually returned
    // (rlast on the final one); gap_mode 0=dense, 1=toggling, 2=random.
    task automatic do_miss(input logic [31:0] addr, input int ar_stall, input int nbeats,
                           input int gap_mode, input bit hold_req, input logic [31:0] base);
        logic [31:0]   beats [$];
        logic [LW-1:0] exp_line;
        logic [31:0]   exp_addr;
        bit            exp_err;
        bit            v;
        int            crit;
        int            beat;
        int            tog;

        exp_addr = (addr >> OFF_W) << OFF_W;
        crit     = int'((addr >> 2) % WORDS);
        for (int i = 0; i < nbeats; i++) begin
            beats.push_back(base + 32'(i));
        end
        exp_line = '0;
        for (int k = 0; k < nbeats && k < WORDS; k++) begin
            exp_line[32*k +: 32] = beats[k];
        end
        exp_err = (nbeats != WORDS);

        // Cycle 0: miss offered together with a stray beat.
        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = addr;
        i_rvalid  = 1'b1;
        i_rdata   = $urandom;
        i_rlast   = 1'($urandom);
        i_arready = 1'($urandom);
        #1;
        check_eq("acc_miss_ready", miss_ready, 1);
        check_eq("acc_arvalid", i_arvalid, 0);
        check_eq("acc_refill_valid", refill_valid, 0);
        check_eq("acc_crit_valid", crit_valid, 0);

        // Address phase, ar_stall cycles of backpressure.
        for (int s = 0; s <= ar_stall; s++) begin
            @(negedge clk);
            miss_req  = 1'($urandom);
            miss_addr = $urandom;
            i_arready = (s == ar_stall);
            i_rvalid  = 1'($urandom);
            i_rdata   = $urandom;
            i_rlast   = 1'($urandom);
            #1;
            check_eq("ar_arvalid", i_arvalid, 1);
            check_eq("ar_araddr", i_araddr, exp_addr);
            check_eq("ar_arlen", i_arlen, WORDS - 1);
            check_eq("ar_rready", i_rready, 0);
            check_eq("ar_miss_ready", miss_ready, 0);
            check_eq("ar_crit_valid", crit_valid, 0);
        end

        // Data phase.
        beat = 0;
        tog  = 0;
        while (beat < nbeats) begin
            @(negedge clk);
            miss_req  = 1'($urandom);
            i_arready = 1'($urandom);
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (tog % 2 == 0);
                default: v = ($urandom % 3 != 0);
            endcase
            tog++;
            i_rvalid = v;
            i_rdata  = v ? beats[beat] : $urandom;
            i_rlast  = v ? (beat == nbeats - 1) : 1'($urandom);
            #1;
            check_eq("r_rready", i_rready, 1);
            check_eq("r_arvalid", i_arvalid, 0);
            check_eq("r_refill_valid", refill_valid, 0);
            check_eq("r_crit_valid", crit_valid, (v && beat == crit));
            if (v && beat == crit) begin
                check_eq("r_crit_data", crit_data, beats[beat]);
            end
            if (v) begin
                beat++;
            end
        end

        // Hand-off cycle; a miss offered here must be ignored.
        @(negedge clk);
        miss_req  = hold_req;
        miss_addr = $urandom;
        i_rvalid  = 1'b1;
        i_rdata   = $urandom;
        i_rlast   = 1'b1;
        #1;
        check_eq("done_refill_valid", refill_valid, 1);
        check_eq("done_refill_addr", refill_addr, exp_addr);
        check_eq("done_refill_line", refill_line, exp_line);
        check_eq("done_refill_err", refill_err, exp_err);
        check_eq("done_crit_valid", crit_valid, 0);
        check_eq("done_rready", i_rready, 0);
        check_eq("done_miss_ready", miss_ready, 0);
        check_eq("done_arvalid", i_arvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          nb;
        bit          hold;

        rst       = 1'b1;
        miss_req  = 1'b0;
        miss_addr = '0;
        i_arready = 1'b0;
        i_rdata   = '0;
        i_rlast   = 1'b0;
        i_rvalid  = 1'b0;

        // Reset values while rst is held.
        @(negedge clk);
        #1;
        check_eq("rst_miss_ready", miss_ready, 1);
        check_eq("rst_arvalid", i_arvalid, 0);
        check_eq("rst_rready", i_rready, 0);
        check_eq("rst_refill_valid", refill_valid, 0);
        check_eq("rst_crit_valid", crit_valid, 0);
        check_eq("rst_refill_err", refill_err, 0);
        check_eq("rst_araddr", i_araddr, 0);
        check_eq("rst_arlen", i_arlen, WORDS - 1);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Basic refill: crit word 5 (0xA5) in cycle 7, refill in cycle 10.
        do_miss(32'h1FC0_0014, 0, WORDS, 0, 1'b0, 32'hA0);
        idle(1);
        // AR backpressure.
        do_miss(32'h2000_1238, 5, WORDS, 0, 1'b0, 32'h1000);
        idle(1);
        // R gaps.
        do_miss(32'h3000_0040, 1, WORDS, 1, 1'b0, 32'h5500);
        idle(1);
        // Early rlast on beat 3.
        do_miss(32'h4000_001C, 0, 4, 0, 1'b0, 32'h7700);
        idle(1);
        // Long burst, two surplus beats.
        do_miss(32'h5000_0008, 0, WORDS + 2, 0, 1'b0, 32'h9900);
        idle(1);

        // Reset after beat 2.
        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = 32'h6000_0010;
        i_rvalid  = 1'b0;
        @(negedge clk);
        miss_req  = 1'b0;
        i_arready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            i_rvalid = 1'b1;
            i_rdata  = 32'hDEAD_0000 + 32'(b);
            i_rlast  = 1'b0;
        end
        @(negedge clk);
        i_rvalid = 1'b0;
        rst      = 1'b1;
        #1;
        check_eq("mrst_rready", i_rready, 0);
        check_eq("mrst_miss_ready", miss_ready, 1);
        check_eq("mrst_refill_valid", refill_valid, 0);
        check_eq("mrst_arvalid", i_arvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        do_miss(32'h6000_0010, 0, 3, 0, 1'b0, 32'hBEE0);
        idle(1);
        do_miss(32'h6000_0010, 0, WORDS, 0, 1'b0, 32'hC0DE0);
        idle(1);

        // Back-to-back misses with miss_req held through DONE.
        do_miss(32'h7000_0004, 0, WORDS, 0, 1'b1, 32'h100);
        do_miss(32'h7000_0104, 0, WORDS, 0, 1'b0, 32'h200);
        idle(1);

        // Randomized misses.
        for (int t = 0; t < 40; t++) begin
            a    = $urandom;
            nb   = ($urandom % 4 == 0) ? int'($urandom_range(1, WORDS + 2)) : WORDS;
            hold = (t != 39) && 1'($urandom);
            do_miss(a, int'($urandom_range(0, 3)), nb, int'($urandom_range(0, 2)), hold, $urandom);
            if (!hold) begin
                idle(int'($urandom_range(0, 2)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
